// File: rtl/mc_maindec.sv
// Multicycle MIPS-subset main control FSM: sequences fetch/decode/execute/mem/writeback
// and drives datapath enables, mux selects and the 2-bit aluop for the ALU decoder.
module mc_maindec #(
  parameter int OPW = 6
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [OPW-1:0] op,
  input  logic           zero,
  input  logic           mem_ready,
  output logic           mem_req,
  output logic           memwrite,
  output logic           iord,
  output logic           irwrite,
  output logic           regdst,
  output logic           memtoreg,
  output logic           regwrite,
  output logic           alusrca,
  output logic [1:0]     alusrcb,
  output logic [1:0]     pcsrc,
  output logic           pcwrite,
  output logic [1:0]     aluop,
  output logic           illegal_op
);

  localparam logic [OPW-1:0] OP_RTYPE = 6'b000000;
  localparam logic [OPW-1:0] OP_LW    = 6'b100011;
  localparam logic [OPW-1:0] OP_SW    = 6'b101011;
  localparam logic [OPW-1:0] OP_BEQ   = 6'b000100;
  localparam logic [OPW-1:0] OP_ADDI  = 6'b001000;
  localparam logic [OPW-1:0] OP_J     = 6'b000010;

  typedef enum logic [3:0] {
    FETCH   = 4'd0,
    DECODE  = 4'd1,
    MEMADR  = 4'd2,
    MEMRD   = 4'd3,
    MEMWB   = 4'd4,
    MEMWR   = 4'd5,
    RTYPEEX = 4'd6,
    RTYPEWB = 4'd7,
    BEQEX   = 4'd8,
    ADDIEX  = 4'd9,
    ADDIWB  = 4'd10,
    JEX     = 4'd11
  } state_t;

  typedef struct packed {
    logic       mem_req;
    logic       memwrite;
    logic       iord;
    logic       irwrite;
    logic       regdst;
    logic       memtoreg;
    logic       regwrite;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [1:0] pcsrc;
    logic       pcwrite;
    logic [1:0] aluop;
    logic       illegal_op;
  } ctrl_t;

  state_t state, nxt;
  ctrl_t  c, co;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= FETCH;
    else        state <= nxt;
  end

  always_comb begin
    nxt = FETCH;
    c   = '0;
    case (state)
      FETCH: begin
        c.mem_req = 1'b1;
        c.alusrcb = 2'b01;
        c.irwrite = mem_ready;
        c.pcwrite = mem_ready;
        nxt       = mem_ready ? DECODE : FETCH;
      end
      DECODE: begin
        c.alusrcb = 2'b11;
        if (op == OP_LW || op == OP_SW) nxt = MEMADR;
        else if (op == OP_RTYPE)        nxt = RTYPEEX;
        else if (op == OP_BEQ)          nxt = BEQEX;
        else if (op == OP_ADDI)         nxt = ADDIEX;
        else if (op == OP_J)            nxt = JEX;
        else                            c.illegal_op = 1'b1;
      end
      MEMADR: begin
        c.alusrca = 1'b1;
        c.alusrcb = 2'b10;
        if (op == OP_LW)      nxt = MEMRD;
        else if (op == OP_SW) nxt = MEMWR;
      end
      MEMRD: begin
        c.mem_req = 1'b1;
        c.iord    = 1'b1;
        nxt       = mem_ready ? MEMWB : MEMRD;
      end
      MEMWB: begin
        c.memtoreg = 1'b1;
        c.regwrite = 1'b1;
      end
      MEMWR: begin
        // strobe only on the completing cycle so a stalled store writes once
        c.mem_req  = 1'b1;
        c.iord     = 1'b1;
        c.memwrite = mem_ready;
        nxt        = mem_ready ? FETCH : MEMWR;
      end
      RTYPEEX: begin
        c.alusrca = 1'b1;
        c.aluop   = 2'b10;
        nxt       = RTYPEWB;
      end
      RTYPEWB: begin
        c.regdst   = 1'b1;
        c.regwrite = 1'b1;
      end
      BEQEX: begin
        c.alusrca = 1'b1;
        c.aluop   = 2'b01;
        c.pcsrc   = 2'b01;
        c.pcwrite = zero;
      end
      ADDIEX: begin
        c.alusrca = 1'b1;
        c.alusrcb = 2'b10;
        nxt       = ADDIWB;
      end
      ADDIWB: c.regwrite = 1'b1;
      JEX: begin
        c.pcsrc   = 2'b10;
        c.pcwrite = 1'b1;
      end
      default: ;
    endcase
  end

  // state already sits in FETCH during reset; mask outputs so nothing is enabled
  assign co = reset ? c : '0;

  assign mem_req    = co.mem_req;
  assign memwrite   = co.memwrite;
  assign iord       = co.iord;
  assign irwrite    = co.irwrite;
  assign regdst     = co.regdst;
  assign memtoreg   = co.memtoreg;
  assign regwrite   = co.regwrite;
  assign alusrca    = co.alusrca;
  assign alusrcb    = co.alusrcb;
  assign pcsrc      = co.pcsrc;
  assign pcwrite    = co.pcwrite;
  assign aluop      = co.aluop;
  assign illegal_op = co.illegal_op;

endmodule
